// File: rtl/tmds_encoder.sv
// -----------------------------------------------------------------------------
// tmds_encoder
//
// Single-channel DVI 1.0 TMDS 8b/10b encoder. One symbol is produced per
// pixel clock. Stage 1 does transition minimisation (q_m plus its popcount).
// Stage 2 does DC balancing against the running disparity, or emits a control
// token while de is low.
//
// Parameters:
//   LATENCY    1 or 2. This is the number of pixel clocks from input to
//              tmds_out. With 2, the stage-1 result is registered. With 1,
//              stage 1 feeds stage 2 combinationally.
//
// Ports:
//   pixel_clk  in   1   pixel clock; everything is on the rising edge
//   rst_n      in   1   asynchronous active-low reset
//   de         in   1   1 = encode d, 0 = emit control token selected by c
//   d          in   8   pixel data byte
//   c          in   2   control bits {c1,c0}
//   tmds_out   out  10  encoded symbol, bit 0 transmitted first (registered)
//   disparity  out  5   signed running disparity after tmds_out (registered)
//
// Handshake: none. One input is accepted every clock. There is no stall and
// no backpressure, and de/d/c advance through the pipeline together.
// -----------------------------------------------------------------------------
module tmds_encoder #(
    parameter int LATENCY = 2
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic       de,
    input  logic [7:0] d,
    input  logic [1:0] c,
    output logic [9:0] tmds_out,
    output logic [4:0] disparity
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'b000, v[i]};
        end
        return sum;
    endfunction

    // ---------------- stage 1: transition minimisation ----------------
    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] q_m;
    logic [3:0] n1q;

    always_comb begin
        n1d      = popcount8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q_m      = 9'd0;
        q_m[0]   = d[0];
        for (int i = 1; i < 8; i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
        end
        q_m[8]   = ~use_xnor;
        n1q      = popcount8(q_m[7:0]);
    end

    // Stage-2 operands. They are either registered or passed straight through.
    // In both cases de and c travel alongside their own q_m.
    logic       s2_de;
    logic [1:0] s2_c;
    logic [8:0] s2_qm;
    logic [3:0] s2_n1q;

    generate
        if (LATENCY == 1) begin : g_comb
            assign s2_de  = de;
            assign s2_c   = c;
            assign s2_qm  = q_m;
            assign s2_n1q = n1q;
        end else begin : g_reg
            always_ff @(posedge pixel_clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_de  <= 1'b0;
                    s2_c   <= 2'b00;
                    s2_qm  <= 9'd0;
                    s2_n1q <= 4'd0;
                end else begin
                    s2_de  <= de;
                    s2_c   <= c;
                    s2_qm  <= q_m;
                    s2_n1q <= n1q;
                end
            end
        end
    endgenerate

    // ---------------- stage 2: DC balance / control tokens ----------------
    // All cnt arithmetic is 5-bit two's complement. The value is bounded to
    // -10..+10, so wrap never occurs.
    logic [4:0] diff;       // n1q - n0q = 2*n1q - 8
    logic [4:0] two_qm8;    // 2*q_m[8]
    logic [4:0] two_nqm8;   // 2*~q_m[8]
    logic       cnt_pos;
    logic       cnt_neg;
    logic [9:0] sym_next;
    logic [4:0] cnt_next;

    always_comb begin
        diff     = {s2_n1q, 1'b0} - 5'd8;
        two_qm8  = {3'b000, s2_qm[8], 1'b0};
        two_nqm8 = {3'b000, ~s2_qm[8], 1'b0};
        cnt_pos  = !disparity[4] && (disparity != 5'd0);
        cnt_neg  = disparity[4];
        sym_next = CTRL_00;
        cnt_next = 5'd0;
        if (s2_de) begin
            if ((disparity == 5'd0) || (s2_n1q == 4'd4)) begin
                sym_next = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
                cnt_next = s2_qm[8] ? (disparity + diff) : (disparity - diff);
            end else if ((cnt_pos && (s2_n1q > 4'd4)) || (cnt_neg && (s2_n1q < 4'd4))) begin
                sym_next = {1'b1, s2_qm[8], ~s2_qm[7:0]};
                cnt_next = disparity + two_qm8 - diff;
            end else begin
                sym_next = {1'b0, s2_qm[8], s2_qm[7:0]};
                cnt_next = disparity + diff - two_nqm8;
            end
        end else begin
            // Blanking restarts DC balance from zero on this very symbol.
            cnt_next = 5'd0;
            case (s2_c)
                2'b00:   sym_next = CTRL_00;
                2'b01:   sym_next = CTRL_01;
                2'b10:   sym_next = CTRL_10;
                default: sym_next = CTRL_11;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmds_out  <= CTRL_00;
            disparity <= 5'd0;
        end else begin
            tmds_out  <= sym_next;
            disparity <= cnt_next;
        end
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_encoder
//
// Self-checking bench for tmds_encoder (LATENCY = 2). A reference encoder
// computes each symbol directly from the DVI rules. It tracks disparity as the
// ones-minus-zeros balance of the emitted 10-bit symbol. Every expected
// result is queued and compared on every falling edge. Directed sequences with
// literal expectations pin the reference model itself.
// -----------------------------------------------------------------------------
module tb_tmds_encoder;

  localparam int LAT = 2;
  localparam logic [9:0] TOK_00 = 10'b1101010100;

  logic       pixel_clk = 1'b0;
  logic       rst_n     = 1'b0;
  logic       de        = 1'b0;
  logic [7:0] d         = 8'd0;
  logic [1:0] c         = 2'd0;
  logic [9:0] tmds_out;
  logic [4:0] disparity;

  int checks = 0;
  int errors = 0;

  // {de, symbol[9:0], disparity[4:0]}
  logic [15:0] exp_q[$];
  // {symbol[9:0], disparity[4:0]} literal expectations
  logic [14:0] lit_q[$];
  int model_cnt = 0;

  tmds_encoder #(.LATENCY(LAT)) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .de        (de),
    .d         (d),
    .c         (c),
    .tmds_out  (tmds_out),
    .disparity (disparity)
  );

  // ---------------- clock ----------------
  always #5 pixel_clk = ~pixel_clk;

  // ---------------- reference model ----------------
  function automatic void model_encode(input logic de_i, input logic [7:0] d_i,
                                       input logic [1:0] c_i, input int cnt_in,
                                       output logic [9:0] sym, output int cnt_out);
    int         ones_d;
    int         ones_q;
    int         bal;
    int         ones_s;
    logic       xnor_mode;
    logic       qm8;
    logic       invert;
    logic [7:0] q;
    if (!de_i) begin
      case (c_i)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      cnt_out = 0;
      return;
    end
    ones_d    = $countones(d_i);
    xnor_mode = (ones_d > 4) || (ones_d == 4 && d_i[0] == 1'b0);
    q[0]      = d_i[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = xnor_mode ? ~(q[i-1] ^ d_i[i]) : (q[i-1] ^ d_i[i]);
    end
    qm8    = ~xnor_mode;
    ones_q = $countones(q);
    bal    = ones_q - (8 - ones_q);
    if (cnt_in == 0 || bal == 0) invert = ~qm8;
    else                         invert = ((cnt_in > 0) == (bal > 0));
    sym     = {invert, qm8, invert ? ~q : q};
    ones_s  = $countones(sym);
    cnt_out = cnt_in + ones_s - (10 - ones_s);
  endfunction

  always @(posedge pixel_clk or negedge rst_n) begin
    logic [9:0] s;
    int         nc;
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      model_encode(de, d, c, model_cnt, s, nc);
      model_cnt = nc;
      exp_q.push_back({de, s, nc[4:0]});
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pixel_clk) begin
    logic [15:0] e;
    logic        exp_de;
    logic [9:0]  exp_sym;
    logic [4:0]  exp_disp;
    int          dv;
    if (exp_q.size() >= LAT) begin
      e        = exp_q.pop_front();
      exp_de   = e[15];
      exp_sym  = e[14:5];
      exp_disp = e[4:0];
    end else begin
      // pipeline still holds its cleared (de=0, c=00) contents
      exp_de   = 1'b0;
      exp_sym  = TOK_00;
      exp_disp = 5'd0;
    end
    check("stream_sym", {6'd0, tmds_out}, {6'd0, exp_sym});
    check("stream_disp", {11'd0, disparity}, {11'd0, exp_disp});
    dv = $signed(disparity);
    checks = checks + 1;
    if (dv > 10 || dv < -10) begin
      errors = errors + 1;
      $display("FAIL disp_bound: got %0d expected within -10..10", dv);
    end
    if (!exp_de) check("blank_disp_zero", {11'd0, disparity}, 16'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic de_i, input logic [7:0] d_i, input logic [1:0] c_i);
    de = de_i;
    d  = d_i;
    c  = c_i;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic check_lit();
    logic [14:0] e;
    e = lit_q.pop_front();
    check("lit_sym", {6'd0, tmds_out}, {6'd0, e[14:5]});
    check("lit_disp", {11'd0, disparity}, {11'd0, e[4:0]});
  endtask

  task automatic lit(input logic de_i, input logic [7:0] d_i, input logic [1:0] c_i,
                     input logic [9:0] s, input int dp);
    lit_q.push_back({s, dp[4:0]});
    drive(de_i, d_i, c_i);
    if (lit_q.size() >= LAT) check_lit();
  endtask

  task automatic flush();
    while (lit_q.size() > 0) begin
      drive(1'b0, 8'd0, 2'b00);
      check_lit();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;

    // reset with arbitrary inputs
    rst_n = 1'b0;
    de    = 1'($urandom);
    d     = 8'($urandom);
    c     = 2'($urandom);
    repeat (3) @(posedge pixel_clk);
    #1;
    check("reset_sym", {6'd0, tmds_out}, {6'd0, TOK_00});
    check("reset_disp", {11'd0, disparity}, 16'd0);
    @(negedge pixel_clk);
    rst_n = 1'b1;

    // first post-reset symbol, then all four control tokens
    lit(1'b0, 8'h00, 2'b01, 10'b0010101011, 0);
    lit(1'b0, 8'h00, 2'b00, 10'b1101010100, 0);
    lit(1'b0, 8'h00, 2'b01, 10'b0010101011, 0);
    lit(1'b0, 8'h00, 2'b10, 10'b0101010100, 0);
    lit(1'b0, 8'h00, 2'b11, 10'b1010101011, 0);
    // 0x00 twice from cnt 0
    lit(1'b1, 8'h00, 2'b00, 10'b0100000000, -8);
    lit(1'b1, 8'h00, 2'b00, 10'b1111111111, 2);
    // data -> control clears cnt, XNOR path for 0xFF
    lit(1'b0, 8'h00, 2'b00, 10'b1101010100, 0);
    lit(1'b1, 8'hFF, 2'b00, 10'b1000000000, -8);
    lit(1'b0, 8'h00, 2'b00, 10'b1101010100, 0);
    lit(1'b1, 8'hFF, 2'b00, 10'b1000000000, -8);
    // single-cycle de pulse
    lit(1'b0, 8'h00, 2'b10, 10'b0101010100, 0);
    lit(1'b1, 8'h00, 2'b00, 10'b0100000000, -8);
    lit(1'b0, 8'h00, 2'b11, 10'b1010101011, 0);
    flush();

    // random video-like stream: 640 active / 160 blank per line
    for (int line = 0; line < 4; line++) begin
      for (int px = 0; px < 800; px++) begin
        if (px < 640) drive(1'b1, 8'($urandom_range(0, 255)), 2'b00);
        else          drive(1'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      end
    end

    // reset mid-stream once disparity reaches -8
    drive(1'b0, 8'h00, 2'b00);
    de = 1'b1;
    d  = 8'h00;
    c  = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pixel_clk);
      if ($signed(disparity) == -8) begin
        found = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!found) begin
      errors = errors + 1;
      $display("FAIL reach_minus8: got %0d expected -8 within 20 cycles", $signed(disparity));
    end
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_sym", {6'd0, tmds_out}, {6'd0, TOK_00});
    check("async_reset_disp", {11'd0, disparity}, 16'd0);
    rst_n = 1'b1;
    repeat (LAT) @(posedge pixel_clk);
    #1;
    check("post_reset_sym", {6'd0, tmds_out}, 16'b0000000100000000);
    check("post_reset_disp", {11'd0, disparity}, {11'd0, 5'b11000});
    repeat (4) drive(1'b0, 8'h00, 2'b00);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
